// File: rtl/reg_file_8x16_if.sv
// reg_file_8x16_if: bus bundle for the 8x16 register file.
//   we       write enable, sampled on the rising clock edge
//   wbe      byte-lane enables (bit 1 = [15:8], bit 0 = [7:0])
//   waddr    write register index
//   wdata    write data
//   raddr_a  read port A index      rdata_a  read port A data (combinational)
//   raddr_b  read port B index      rdata_b  read port B data (combinational)
//   wr_count wrapping count of committed writes
// master: the datapath/bench driving the file; slave: the register file.
interface reg_file_8x16_if #(
  parameter int DW = 16,
  parameter int AW = 3
);
  logic          we;
  logic [1:0]    wbe;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] raddr_a;
  logic [AW-1:0] raddr_b;
  logic [DW-1:0] rdata_a;
  logic [DW-1:0] rdata_b;
  logic [7:0]    wr_count;

  modport master (
    output we, wbe, waddr, wdata, raddr_a, raddr_b,
    input  rdata_a, rdata_b, wr_count
  );

  modport slave (
    input  we, wbe, waddr, wdata, raddr_a, raddr_b,
    output rdata_a, rdata_b, wr_count
  );
endinterface

// File: rtl/reg_file_8x16.sv
// reg_file_8x16: eight-entry, 16-bit register file for the single-cycle CPU.
//   clk  rising-edge clock for all state
//   rst  asynchronous active-high reset: R1-R6 <= 0, R7 <= SP_INIT, count <= 0
//   bus  reg_file_8x16_if.slave: one byte-laned write port, two
//        combinational read ports, committed-write counter.
// R0 is hardwired zero and has no storage. Reads come straight from the
// stored array with no write-to-read bypass, so rdata never depends on wdata.
module reg_file_8x16 #(
  parameter int            DW      = 16,
  parameter int            AW      = 3,
  parameter logic [DW-1:0] SP_INIT = 16'hFFF0
) (
  input logic            clk,
  input logic            rst,
  reg_file_8x16_if.slave bus
);
  localparam int NREG = 1 << AW;
  localparam int BW   = DW / 2;

  // Storage exists only for R1..R(NREG-1).
  logic [DW-1:0] regs_q [NREG-1:1];
  logic [DW-1:0] regs_d [NREG-1:1];
  logic [7:0]    wr_count_q;
  logic [7:0]    wr_count_d;
  logic          commit_s;
  logic [DW-1:0] rdata_a_s;
  logic [DW-1:0] rdata_b_s;

  // Merge new data into the old word lane by lane.
  function automatic logic [DW-1:0] merge_lanes(
    input logic [DW-1:0] old_v,
    input logic [DW-1:0] new_v,
    input logic [1:0]    be
  );
    logic [DW-1:0] res;
    res = old_v;
    if (be[1]) begin
      res[DW-1:BW] = new_v[DW-1:BW];
    end else begin
      res[DW-1:BW] = old_v[DW-1:BW];
    end
    if (be[0]) begin
      res[BW-1:0] = new_v[BW-1:0];
    end else begin
      res[BW-1:0] = old_v[BW-1:0];
    end
    return res;
  endfunction

  // A write only counts when it targets a real register and touches a lane.
  always_comb begin
    commit_s = bus.we && (bus.waddr != {AW{1'b0}}) && (bus.wbe != 2'b00);
  end

  // Next-state for the register array and the write counter.
  always_comb begin
    for (int i = 1; i < NREG; i++) begin
      if (commit_s && (bus.waddr == AW'(i))) begin
        regs_d[i] = merge_lanes(regs_q[i], bus.wdata, bus.wbe);
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
    if (commit_s) begin
      wr_count_d = wr_count_q + 8'd1;
    end else begin
      wr_count_d = wr_count_q;
    end
  end

  // State registers; reset wins over any write sampled on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) begin
        regs_q[i] <= (i == NREG - 1) ? SP_INIT : {DW{1'b0}};
      end
      wr_count_q <= 8'd0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wr_count_q <= wr_count_d;
    end
  end

  // Read ports: an address of 0 falls through to the zero default.
  always_comb begin
    rdata_a_s = {DW{1'b0}};
    rdata_b_s = {DW{1'b0}};
    for (int i = 1; i < NREG; i++) begin
      if (bus.raddr_a == AW'(i)) begin
        rdata_a_s = regs_q[i];
      end else begin
        rdata_a_s = rdata_a_s;
      end
      if (bus.raddr_b == AW'(i)) begin
        rdata_b_s = regs_q[i];
      end else begin
        rdata_b_s = rdata_b_s;
      end
    end
  end

  assign bus.rdata_a  = rdata_a_s;
  assign bus.rdata_b  = rdata_b_s;
  assign bus.wr_count = wr_count_q;
endmodule

// File: tb/tb_reg_file_8x16.sv
module tb_reg_file_8x16;
  logic clk;
  logic rst;
  logic clk_run;
  int   checks;
  int   errors;

  reg_file_8x16_if #(.DW(16), .AW(3)) rf_if ();

  reg_file_8x16 #(.DW(16), .AW(3), .SP_INIT(16'hFFF0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rf_if)
  );

  // clock runs only once clk_run is set, so reset can be checked clockless
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  // behavioural reference model
  logic [15:0] m_regs [8];
  logic [7:0]  m_cnt;

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_regs[7] = 16'hFFF0;
    m_cnt = 8'd0;
  endfunction

  function automatic void model_write(logic we, logic [1:0] be, logic [2:0] a, logic [15:0] d);
    if (we && a != 3'd0) begin
      if (be[1]) m_regs[a][15:8] = d[15:8];
      if (be[0]) m_regs[a][7:0]  = d[7:0];
      if (be != 2'b00) m_cnt = m_cnt + 8'd1;
    end
  endfunction

  function automatic logic [15:0] model_read(logic [2:0] a);
    return (a == 3'd0) ? 16'h0000 : m_regs[a];
  endfunction

  task automatic check16(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act=%h req=%h", name, act, exp);
    end
  endtask

  task automatic check8(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act=%h req=%h", name, act, exp);
    end
  endtask

  // one clocked write: drive at negedge, sample #1 after the posedge
  task automatic do_cycle(logic we, logic [1:0] be, logic [2:0] wa, logic [15:0] wd,
                          logic [2:0] ra, logic [2:0] rb);
    @(negedge clk);
    rf_if.we = we; rf_if.wbe = be; rf_if.waddr = wa; rf_if.wdata = wd;
    rf_if.raddr_a = ra; rf_if.raddr_b = rb;
    @(posedge clk);
    #1;
    model_write(we, be, wa, wd);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  wbe;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic [7:0]  exp_cnt;
  } vec_t;

  function automatic vec_t mk(logic we, logic [1:0] be, logic [2:0] wa, logic [15:0] wd,
                              logic [2:0] ra, logic [2:0] rb,
                              logic [15:0] ea, logic [15:0] eb, logic [7:0] ec);
    vec_t v;
    v.we = we; v.wbe = be; v.waddr = wa; v.wdata = wd;
    v.ra = ra; v.rb = rb; v.exp_a = ea; v.exp_b = eb; v.exp_cnt = ec;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    checks = 0;
    errors = 0;
    clk_run = 1'b0;
    rst = 1'b0;
    rf_if.we = 1'b0; rf_if.wbe = 2'b00; rf_if.waddr = 3'd0; rf_if.wdata = 16'h0000;
    rf_if.raddr_a = 3'd0; rf_if.raddr_b = 3'd0;

    // full write/readback R1..R7, then byte lanes, null write, R0, we=0
    for (int k = 1; k < 8; k++) begin
      logic [15:0] val;
      val = 16'h1111 * 16'(k);
      vecs.push_back(mk(1'b1, 2'b11, 3'(k), val, 3'(k), 3'(k), val, val, 8'(k)));
    end
    vecs.push_back(mk(1'b1, 2'b11, 3'd3, 16'hABCD, 3'd3, 3'd7, 16'hABCD, 16'h7777, 8'd8));
    vecs.push_back(mk(1'b1, 2'b01, 3'd3, 16'h1234, 3'd3, 3'd1, 16'hAB34, 16'h1111, 8'd9));
    vecs.push_back(mk(1'b1, 2'b10, 3'd3, 16'h5678, 3'd3, 3'd3, 16'h5634, 16'h5634, 8'd10));
    vecs.push_back(mk(1'b1, 2'b00, 3'd3, 16'h9999, 3'd3, 3'd2, 16'h5634, 16'h2222, 8'd10));
    vecs.push_back(mk(1'b1, 2'b11, 3'd0, 16'hFFFF, 3'd0, 3'd0, 16'h0000, 16'h0000, 8'd10));
    vecs.push_back(mk(1'b0, 2'b11, 3'd4, 16'h0000, 3'd4, 3'd6, 16'h4444, 16'h6666, 8'd10));
    vecs.push_back(mk(1'b1, 2'b11, 3'd5, 16'h00AA, 3'd5, 3'd0, 16'h00AA, 16'h0000, 8'd11));

    // reset with no clock
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int a = 0; a < 8; a++) begin
      rf_if.raddr_a = 3'(a);
      rf_if.raddr_b = 3'(7 - a);
      #1;
      check16("reset_rdata_a", rf_if.rdata_a, (a == 7) ? 16'hFFF0 : 16'h0000);
      check16("reset_rdata_b", rf_if.rdata_b, (a == 0) ? 16'hFFF0 : 16'h0000);
    end
    check8("reset_wr_count", rf_if.wr_count, 8'd0);

    clk_run = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      do_cycle(vecs[i].we, vecs[i].wbe, vecs[i].waddr, vecs[i].wdata, vecs[i].ra, vecs[i].rb);
      check16($sformatf("vec%0d_rdata_a", i), rf_if.rdata_a, vecs[i].exp_a);
      check16($sformatf("vec%0d_rdata_b", i), rf_if.rdata_b, vecs[i].exp_b);
      check8($sformatf("vec%0d_wr_count", i), rf_if.wr_count, vecs[i].exp_cnt);
    end

    // no bypass: pending write to R5 not visible until after the edge
    @(negedge clk);
    rf_if.we = 1'b1; rf_if.wbe = 2'b11; rf_if.waddr = 3'd5; rf_if.wdata = 16'h00BB;
    rf_if.raddr_a = 3'd5; rf_if.raddr_b = 3'd5;
    #1;
    check16("nobypass_before", rf_if.rdata_a, 16'h00AA);
    @(posedge clk);
    #1;
    model_write(1'b1, 2'b11, 3'd5, 16'h00BB);
    check16("nobypass_after", rf_if.rdata_a, 16'h00BB);
    check8("nobypass_count", rf_if.wr_count, 8'd12);

    // reset during write: reset wins
    @(negedge clk);
    rf_if.we = 1'b1; rf_if.wbe = 2'b11; rf_if.waddr = 3'd2; rf_if.wdata = 16'hBEEF;
    rf_if.raddr_a = 3'd2; rf_if.raddr_b = 3'd7;
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check16("rstwr_r2", rf_if.rdata_a, 16'h0000);
    check16("rstwr_r7", rf_if.rdata_b, 16'hFFF0);
    check8("rstwr_count", rf_if.wr_count, 8'd0);
    // release with a write presented: commits on the first rst=0 edge
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_write(1'b1, 2'b11, 3'd2, 16'hBEEF);
    check16("release_first_write", rf_if.rdata_a, 16'hBEEF);
    check8("release_count", rf_if.wr_count, 8'd1);

    // counter wrap: 255 more writes bring it to 256 committed -> 0
    for (int i = 0; i < 255; i++) begin
      do_cycle(1'b1, 2'($urandom_range(1, 3)), 3'($urandom_range(1, 7)), 16'($urandom),
               3'd1, 3'd6);
    end
    check8("wrap_256", rf_if.wr_count, 8'h00);
    do_cycle(1'b1, 2'b11, 3'd4, 16'hC0DE, 3'd4, 3'd0);
    check8("wrap_257", rf_if.wr_count, 8'h01);
    check16("wrap_r4", rf_if.rdata_a, 16'hC0DE);

    // randomized traffic against the model, with occasional async resets
    for (int i = 0; i < 400; i++) begin
      logic        we;
      logic [1:0]  be;
      logic [2:0]  wa;
      logic [2:0]  ra;
      logic [2:0]  rb;
      logic [15:0] wd;
      we = 1'($urandom_range(0, 3) != 0);
      be = 2'($urandom);
      wa = 3'($urandom);
      wd = 16'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom);
      rb = 3'($urandom);
      @(negedge clk);
      rf_if.we = we; rf_if.wbe = be; rf_if.waddr = wa; rf_if.wdata = wd;
      rf_if.raddr_a = ra; rf_if.raddr_b = rb;
      #1;
      check16("rand_pre_a", rf_if.rdata_a, model_read(ra));
      check16("rand_pre_b", rf_if.rdata_b, model_read(rb));
      if ($urandom_range(0, 39) == 0) begin
        #1 rst = 1'b1;
        #1;
        model_reset();
        check16("rand_async_rst_a", rf_if.rdata_a, model_read(ra));
        check16("rand_async_rst_b", rf_if.rdata_b, model_read(rb));
        check8("rand_async_rst_cnt", rf_if.wr_count, 8'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        rf_if.we = 1'b0;
      end else begin
        @(posedge clk);
        #1;
        model_write(we, be, wa, wd);
        check16("rand_post_a", rf_if.rdata_a, model_read(ra));
        check16("rand_post_b", rf_if.rdata_b, model_read(rb));
        check8("rand_post_cnt", rf_if.wr_count, m_cnt);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_8x16.md
# reg_file_8x16

- Eight-entry, 16-bit general-purpose register file for the single-cycle CPU datapath.
- Two combinational read ports supply the ALU operand and writeback source selectors.
- One synchronous write port takes the writeback result, with byte-lane enables.
- Sits directly upstream of the 16-bit 4:1 operand/writeback muxes; `rdata_a` and `rdata_b` drive their data inputs.

## Interface

Parameters:
- `DW`, 16: data width; only 16 is supported, because byte lanes assume two bytes.
- `AW`, 3: register address width, giving 2^AW = 8 registers.
- `SP_INIT`, 16'hFFF0: reset value of R7, the stack pointer.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high; clears or initialises every register immediately.
- `we`  in  1  write enable, sampled at the rising edge of `clk`.
- `wbe`  in  2  byte-lane enable; bit 1 = bits 15:8, bit 0 = bits 7:0.
- `waddr`  in  AW  write register index.
- `wdata`  in  DW  write data.
- `raddr_a`  in  AW  read port A index.
- `raddr_b`  in  AW  read port B index.
- `rdata_a`  out  DW  read port A data, combinational.
- `rdata_b`  out  DW  read port B data, combinational.
- `wr_count`  out  8  count of committed writes, wrapping; debug/verification visibility.

## Operation

Register roles:
- R0 is hardwired zero: reads always return 16'h0000, and writes to it are discarded.
- R1–R6 are general purpose.
- R7 is general purpose with a distinct reset value of `SP_INIT`.

Write commit:
- A write commits at a rising edge only when all three hold: `rst`=0, `we`=1, `waddr`≠0.
- Lanes update independently:
  - `wbe[1]`=1: R[waddr][15:8] ← `wdata[15:8]`.
  - `wbe[0]`=1: R[waddr][7:0] ← `wdata[7:0]`.
  - A lane whose enable is 0 keeps its old value.
- `wbe`=2'b00 with `we`=1 is a null write: no data changes and `wr_count` does not increment.

Write counter:
- `wr_count` increments by 1 on each committed write, meaning `waddr`≠0 and `wbe`≠0.
- It wraps 8'hFF → 8'h00.
- Writes to R0 are not counted.

Reads:
- Purely combinational from the stored array: `rdata_x` = R[raddr_x].
- Any change on `raddr_x` or on the stored contents propagates in the same cycle.
- There is no write-to-read bypass. A read of `waddr` in the cycle a write is pending returns the old value; the new value appears after the edge. This is required so that the single-cycle ALU path has no combinational loop from `wdata` back to `rdata`.
- Both ports may address the same register, or R0, simultaneously; each returns the same value independently.

Reset:
- While `rst`=1: R1–R6 = 0, R7 = `SP_INIT`, `wr_count` = 0.
- Therefore `rdata_a` = `rdata_b` = 0 unless a port addresses R7, in which case it returns `SP_INIT`.
- Writes presented while `rst`=1 are ignored.
- Reset asserted mid-cycle overrides any write on the same edge: reset wins.

## Timing

- Read latency is 0 cycles (combinational).
- Write latency is 1 edge: data visible on read ports after the rising edge that samples `we`=1.
- `wr_count` updates on the same edge as the write it counts.
- Reset takes effect asynchronously on `rst` rising, with no clock needed.
- Release is synchronous in effect: the first write can commit at the first rising edge where `rst`=0.
- Back-to-back writes every cycle are supported; there are no stalls and no handshake.
- Two writes to the same register on consecutive edges: the second overwrites the first, except in lanes where its `wbe` bit is 0.

## Test plan

1. **Reset:** assert `rst` with no clock.
   - Every `raddr` 0–6 → 16'h0000.
   - `raddr`=7 → 16'hFFF0.
   - `wr_count`=0.
2. **Full write/readback:** write 16'h1111×k to R1–R7 (`wbe`=11), then read all.
   - Each Rk returns its value on both ports.
   - `wr_count`=7.
3. **Byte lanes:** R3=16'hABCD.
   - Write 16'h1234 with `wbe`=01 → R3=16'hAB34.
   - Write 16'h5678 with `wbe`=10 → R3=16'h5634.
   - Write with `wbe`=00 → unchanged, `wr_count` not incremented.
4. **R0 and no bypass:**
   - Write 16'hFFFF to R0 → reads 0, `wr_count` unchanged.
   - With R5=16'h00AA, present a write of 16'h00BB to R5 while `raddr_a`=5: `rdata_a`=16'h00AA before the edge, 16'h00BB after it.
5. **Reset during write:** `we`=1, `waddr`=2, `wdata`=16'hBEEF, and `rst` asserted in the same cycle → R2=0 after the edge, `wr_count`=0.
6. **Counter wrap:** perform 256 committed writes → `wr_count` returns to 8'h00; the 257th write gives 8'h01.
